reload_scheduler: RTL and testbench
===================================

# reload_scheduler

Upstream sequencer for `reload_counter`. Buffers a queue of reload values written by a producer and issues each one to the counter as a one-cycle `load_i` strobe with its value, timed exactly at the counter's terminal count, so consecutive count segments run back-to-back with no wrap cycle in between. It also flags underrun when the queue runs dry.

## Interface
Parameters:
- `WIDTH`, 4: counter and reload value width; must match `reload_counter`.
- `DEPTH`, 4: reload FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
- `wr_valid_i`  in  1  producer offers `wr_data_i`.
- `wr_data_i`  in  WIDTH  reload value to enqueue.
- `wr_ready_o`  out  1  FIFO can accept; high iff level < DEPTH.
- `count_in`  in  WIDTH  `count_out` of `reload_counter`.
- `load_i_o`  out  1  to counter `load_i`; one-cycle strobe.
- `load_o`  out  WIDTH  to counter `load`; valid when `load_i_o`=1.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `underrun_o`  out  1  sticky; set when terminal count is reached with FIFO empty in RUN.

## Operation
- FIFO: circular buffer; write when `wr_valid_i && wr_ready_o`; pop when `load_i_o`=1 (except in repeat mode, below). Simultaneous write and pop: both occur, level unchanged. When full, `wr_ready_o`=0 even if a pop happens that cycle.
- Terminal count: TC = (`count_in` == {WIDTH{1'b1}}).
- FSM states IDLE, RUN; reset → IDLE.
  - IDLE: `load_i_o` = !empty. When asserted, pop the head and go to RUN. `count_in` is ignored.
  - RUN: `load_i_o` = TC && !empty. On TC with FIFO non-empty: pop, stay in RUN. On TC with FIFO empty: set `underrun_o`, go to IDLE. The counter free-wraps until a value arrives.
- `load_o` = FIFO head (or last-issued value in repeat mode); 0 when FIFO empty and no repeat.
- Reload value all-ones: the counter shows F for one cycle, then TC triggers the next pop immediately. This is legal.
- `underrun_o` is cleared only by reset.

## Timing
- `load_i_o`/`load_o` are combinational from state, FIFO head and `count_in`. They assert in the same cycle `count_in`=F, and the counter loads on the next edge. No wrap bubble.
- A segment loaded with value v lasts 2^WIDTH − v cycles (v..F inclusive).
- Written value visible at head the cycle after the write edge. Write-to-load latency from IDLE with empty FIFO: 1 cycle.
- Reset values: FIFO empty, `level_o`=0, `wr_ready_o`=1, `load_i_o`=0, `load_o`=0, `underrun_o`=0, state IDLE.
- Reset asserted mid-segment clears everything asynchronously. A pending strobe is dropped and the queue is discarded.

## Configuration
- `RELOAD_SCHED_REPEAT_EN`
  - Defined: a last-value register is loaded on every pop (reset 0). In RUN on TC with FIFO empty, `load_i_o`=1 with `load_o` = last value. No pop, no underrun, state stays RUN, so the block repeats the last segment indefinitely.
  - Undefined: underrun behaviour as above, and no last-value register is built.

## Test plan
- Reset, write 0, 3, 6 back-to-back, counter connected. Required: load strobes at 1 cycle after the first write, then after segments of 16, 13 and 10 cycles. `count_in` never shows a wrap 0 between segments. `underrun_o`=1 after the third TC.
- Write 5 values with DEPTH=4 and no pops (hold `count_in`≠F in RUN). Required: `wr_ready_o`=0 after the 4th write, `level_o`=4, and the 5th value is not accepted.
- Write on the same cycle as a TC pop with level=2. Required: level stays 2 and FIFO order is preserved.
- Reload F. Required: `load_i_o` high on two consecutive TC cycles, with a segment of 1 cycle.
- Assert `reset` mid-segment with 3 entries queued. Required: all outputs return to reset values immediately (asynchronously), and the next write restarts from IDLE.
- With `RELOAD_SCHED_REPEAT_EN`: write 10 only. Required: the counter reloads 10 every 6 cycles indefinitely and `underrun_o` stays 0.

Source files
------------

// File: rtl/reload_scheduler_if.sv
// reload_scheduler_if: bundles the producer write channel and the counter-side
// signals of reload_scheduler.
//   wr_valid_i/wr_data_i/wr_ready_o : producer enqueue handshake
//   count_in                        : count_out of reload_counter
//   load_i_o/load_o                 : reload strobe and value to reload_counter
//   level_o/underrun_o              : FIFO occupancy and sticky underrun flag
// Modports: slave = scheduler, master = producer/counter side.
interface reload_scheduler_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic             wr_valid_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             wr_ready_o;
    logic [WIDTH-1:0] count_in;
    logic             load_i_o;
    logic [WIDTH-1:0] load_o;
    logic [LW-1:0]    level_o;
    logic             underrun_o;

    modport slave (
        input  wr_valid_i, wr_data_i, count_in,
        output wr_ready_o, load_i_o, load_o, level_o, underrun_o
    );

    modport master (
        output wr_valid_i, wr_data_i, count_in,
        input  wr_ready_o, load_i_o, load_o, level_o, underrun_o
    );
endinterface

// File: rtl/reload_scheduler.sv
// reload_scheduler: queues reload values and issues each one to reload_counter
// as a one-cycle load strobe exactly on the counter's terminal count, so
// segments run back-to-back with no wrap cycle. Flags sticky underrun when
// the queue is empty at terminal count.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : reload_scheduler_if.slave (write channel, counter side, status)
// Optional feature macro: RELOAD_SCHED_REPEAT_EN -- when defined, an empty
// queue at terminal count re-issues the last popped value instead of
// flagging underrun.
module reload_scheduler #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    reload_scheduler_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic             underrun;

    logic             empty, full, tc, push, pop, load_i, set_underrun;
    logic [WIDTH-1:0] load_val;

`ifdef RELOAD_SCHED_REPEAT_EN
    logic [WIDTH-1:0] last_val;
`endif

    assign empty = (level == LW'(0));
    assign full  = (level == LW'(DEPTH));
    assign tc    = (bus.count_in == {WIDTH{1'b1}});
    // Full blocks writes even when a pop happens in the same cycle.
    assign push  = bus.wr_valid_i && !full;

    // Next-state and strobe decode.
    always_comb begin
        next_state   = state;
        load_i       = 1'b0;
        pop          = 1'b0;
        set_underrun = 1'b0;
`ifdef RELOAD_SCHED_REPEAT_EN
        load_val     = empty ? last_val : mem[rd_ptr];
`else
        load_val     = empty ? '0 : mem[rd_ptr];
`endif
        case (state)
            IDLE: begin
                // count_in is ignored here: the first value loads immediately.
                if (!empty) begin
                    load_i     = 1'b1;
                    pop        = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (tc) begin
                    if (!empty) begin
                        load_i = 1'b1;
                        pop    = 1'b1;
                    end else begin
`ifdef RELOAD_SCHED_REPEAT_EN
                        // Replay the last segment; queue stays empty.
                        load_i = 1'b1;
`else
                        set_underrun = 1'b1;
                        next_state   = IDLE;
`endif
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, pointers, level and sticky flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            underrun <= 1'b0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (set_underrun) underrun <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data_i;
    end

`ifdef RELOAD_SCHED_REPEAT_EN
    // Last-issued value, refreshed on every pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_val <= '0;
        else if (pop) last_val <= mem[rd_ptr];
    end
`endif

    assign bus.wr_ready_o = !full;
    assign bus.level_o    = level;
    assign bus.underrun_o = underrun;
    assign bus.load_i_o   = load_i;
    assign bus.load_o     = load_val;

endmodule

// File: tb/tb_reload_scheduler.sv
// tb_reload_scheduler: directed table vectors with a manually driven count_in,
// then multi-cycle sequences with a reload_counter model closing the loop.
module tb_reload_scheduler;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
`ifdef RELOAD_SCHED_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk;
    logic reset;
    logic use_model;
    logic [3:0] man_count;
    logic [3:0] cnt;

    int checks;
    int failures;

    reload_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reload_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reload_counter: load on strobe, otherwise free-wrap.
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 4'd0;
        else if (bus.load_i_o) cnt <= bus.load_o;
        else cnt <= cnt + 4'd1;
    end

    assign bus.count_in = use_model ? cnt : man_count;

    typedef struct {
        logic       wv;
        logic [3:0] wd;
        logic [3:0] cin;
        logic       e_li;
        logic [3:0] e_ld;
        logic [2:0] e_lvl;
        logic       e_rdy;
        logic       e_und;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Drive inputs on the falling edge and let combinational outputs settle.
    task automatic cyc(input logic wv, input logic [3:0] wd);
        @(negedge clk);
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.wr_valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [3:0] wa [3];
    int         s_cyc[$];
    int         s_val[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        use_model = 1'b0;
        man_count = 4'd0;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i = 4'd0;
        wa[0] = 4'd0; wa[1] = 4'd3; wa[2] = 4'd6;

        // Reset state (asserted from time zero)
        #2;
        chk("rst_level", int'(bus.level_o), 0);
        chk("rst_ready", int'(bus.wr_ready_o), 1);
        chk("rst_load_i", int'(bus.load_i_o), 0);
        chk("rst_load", int'(bus.load_o), 0);
        chk("rst_underrun", int'(bus.underrun_o), 0);
        @(negedge clk);
        reset = 1'b1;

        // Table: fill to full, reject 5th write, TC pops, write+pop, drain.
        vt.push_back('{1'b1, 4'd2,  4'd0,  1'b0, 4'd0,  3'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 4'd5,  4'd0,  1'b1, 4'd2,  3'd1, 1'b1, 1'b0});
        vt.push_back('{1'b1, 4'd7,  4'd0,  1'b0, 4'd5,  3'd1, 1'b1, 1'b0});
        vt.push_back('{1'b1, 4'd9,  4'd0,  1'b0, 4'd5,  3'd2, 1'b1, 1'b0});
        vt.push_back('{1'b1, 4'd11, 4'd0,  1'b0, 4'd5,  3'd3, 1'b1, 1'b0});
        vt.push_back('{1'b1, 4'd12, 4'd0,  1'b0, 4'd5,  3'd4, 1'b0, 1'b0});
        vt.push_back('{1'b1, 4'd13, 4'd15, 1'b1, 4'd5,  3'd4, 1'b0, 1'b0});
        vt.push_back('{1'b1, 4'd1,  4'd15, 1'b1, 4'd7,  3'd3, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'd0,  4'd3,  1'b0, 4'd9,  3'd3, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'd0,  4'd15, 1'b1, 4'd9,  3'd3, 1'b1, 1'b0});
        vt.push_back('{1'b1, 4'd4,  4'd15, 1'b1, 4'd11, 3'd2, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'd0,  4'd15, 1'b1, 4'd1,  3'd2, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'd0,  4'd15, 1'b1, 4'd4,  3'd1, 1'b1, 1'b0});
        vt.push_back('{1'b0, 4'd0,  4'd0,  1'b0, REP ? 4'd4 : 4'd0, 3'd0, 1'b1, 1'b0});
        if (!REP) begin
            vt.push_back('{1'b0, 4'd0, 4'd15, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0});
            vt.push_back('{1'b0, 4'd0, 4'd15, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1});
            vt.push_back('{1'b1, 4'd6, 4'd15, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1});
            vt.push_back('{1'b0, 4'd0, 4'd8,  1'b1, 4'd6, 3'd1, 1'b1, 1'b1});
            vt.push_back('{1'b0, 4'd0, 4'd8,  1'b0, 4'd0, 3'd0, 1'b1, 1'b1});
        end
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            bus.wr_valid_i = vt[i].wv;
            bus.wr_data_i  = vt[i].wd;
            man_count      = vt[i].cin;
            #1;
            chk($sformatf("v%0d_load_i", i), int'(bus.load_i_o),   int'(vt[i].e_li));
            chk($sformatf("v%0d_load", i),   int'(bus.load_o),     int'(vt[i].e_ld));
            chk($sformatf("v%0d_level", i),  int'(bus.level_o),    int'(vt[i].e_lvl));
            chk($sformatf("v%0d_ready", i),  int'(bus.wr_ready_o), int'(vt[i].e_rdy));
            chk($sformatf("v%0d_under", i),  int'(bus.underrun_o), int'(vt[i].e_und));
        end

        // Sequence A: 0,3,6 back-to-back with the counter connected.
        use_model = 1'b1;
        do_reset();
        for (int k = 0; k < 45; k++) begin
            if (k < 3) cyc(1'b1, wa[k]);
            else cyc(1'b0, 4'd0);
            if (bus.load_i_o) begin
                s_cyc.push_back(k);
                s_val.push_back(int'(bus.load_o));
            end
            if (k == 18) chk("a_cnt_after_seg1", int'(bus.count_in), 3);
            if (k == 31) chk("a_cnt_after_seg2", int'(bus.count_in), 6);
            if (k == 30) chk("a_under_early", int'(bus.underrun_o), 0);
            if (!REP && k == 41) chk("a_underrun", int'(bus.underrun_o), 1);
        end
        chk("a_strobes_min", int'(s_cyc.size() >= 3), 1);
        if (!REP) chk("a_strobes", s_cyc.size(), 3);
        for (int i = 0; i < 3 && i < s_cyc.size(); i++) begin
            chk($sformatf("a_cyc%0d", i), s_cyc[i], (i == 0) ? 1 : (i == 1) ? 17 : 30);
            chk($sformatf("a_val%0d", i), s_val[i], int'(wa[i]));
        end

        // Sequence B: reload F gives strobes on two consecutive TC cycles.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 0 || k == 1) cyc(1'b1, 4'd15);
            else if (k == 2) cyc(1'b1, 4'd5);
            else cyc(1'b0, 4'd0);
            if (k == 1) chk("b_first_li", int'(bus.load_i_o), 1);
            if (k == 2 || k == 3) begin
                chk($sformatf("b_tc%0d_cnt", k), int'(bus.count_in), 15);
                chk($sformatf("b_tc%0d_li", k), int'(bus.load_i_o), 1);
                chk($sformatf("b_tc%0d_ld", k), int'(bus.load_o), (k == 2) ? 15 : 5);
            end
            if (k == 4) begin
                chk("b_cnt_after", int'(bus.count_in), 5);
                chk("b_li_after", int'(bus.load_i_o), 0);
            end
            if (!REP && k == 15) chk("b_underrun", int'(bus.underrun_o), 1);
        end

        // Sequence C: async reset mid-segment with entries queued.
        if (!REP) begin
            for (int k = 0; k < 6; k++) begin
                if (k < 4) cyc(1'b1, 4'(k + 1));
                else cyc(1'b0, 4'd0);
            end
            chk("c_level_pre", int'(bus.level_o), 3);
        end else begin
            do_reset();
            for (int k = 0; k < 6; k++) begin
                if (k < 4) cyc(1'b1, 4'(k + 1));
                else cyc(1'b0, 4'd0);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        chk("c_level", int'(bus.level_o), 0);
        chk("c_ready", int'(bus.wr_ready_o), 1);
        chk("c_load_i", int'(bus.load_i_o), 0);
        chk("c_load", int'(bus.load_o), 0);
        chk("c_underrun", int'(bus.underrun_o), 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 4'd9);
        chk("c_restart_li0", int'(bus.load_i_o), 0);
        cyc(1'b0, 4'd0);
        chk("c_restart_li", int'(bus.load_i_o), 1);
        chk("c_restart_ld", int'(bus.load_o), 9);

`ifdef RELOAD_SCHED_REPEAT_EN
        // Sequence R: single value 10 repeats every 6 cycles.
        do_reset();
        for (int k = 0; k < 31; k++) begin
            if (k == 0) cyc(1'b1, 4'd10);
            else cyc(1'b0, 4'd0);
            if (k >= 1) begin
                chk($sformatf("r%0d_li", k), int'(bus.load_i_o), int'((k - 1) % 6 == 0));
                if (bus.load_i_o) chk($sformatf("r%0d_ld", k), int'(bus.load_o), 10);
            end
            chk($sformatf("r%0d_under", k), int'(bus.underrun_o), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
